exc_stack_ctrl: RTL and testbench
=================================

EXC_STACK_CTRL -- requirements
Module: exc_stack_ctrl

Interface
REQ-001 SHALL have parameter VTOR_BASE, default 32'h0000_0000, vector table base byte address.
REQ-002 SHALL have ports; one clock; reset is synchronous and active-high:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- exc_req  in  1  exception entry request
- exc_num  in  6  exception number, sampled with exc_req
- exc_ret  in  1  exception return request
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address (bits 1:0 = 0)
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ready
- mem_ready  in  1  beat accepted/completed this cycle
- addr_Rn  out  4  register-file read index
- Rn  in  32  register-file read data
- r_SP, r_LR, r_PC  in  32 each  current SP/LR/PC
- r_APSR  in  4  NZCV
- r_IPSR  in  6  current exception number
- r_PMask  in  1  PRIMASK bit
- ld_sp/w_SP, ld_lr/w_LR, ld_pc/w_PC  out  1/32 each  load strobe and data
- ld_rd  out  1, addr_Rd  out  4, w_Rd  out  32  general register load
- ld_apsr  out  1, w_APSR  out  4  flag load
- ld_ipsr  out  1, w_IPSR  out  6  exception-number load

Function
REQ-003 SHALL implement the states IDLE, PUSH, VEC, ENTER, POP and RET.
REQ-004 SHALL, in IDLE, accept exc_req (entry) and otherwise exc_ret (exit); exc_req SHALL win if both are high; requests outside IDLE SHALL be ignored, not queued.
REQ-005 SHALL map frame beat k (0..7) to R0, R1, R2, R3, R12, LR, PC, xPSR; xPSR word = {APSR[3:0], 22'b0, IPSR[5:0]}.
REQ-006 SHALL, on entry accept, latch base = r_SP - 32 and exc_num, then go to PUSH.
REQ-007 SHALL, in PUSH, write beat k to base + 4k with mem_we=1 and data taken via addr_Rn/Rn or r_LR/r_PC/r_APSR/r_IPSR; the beat SHALL advance only on mem_ready.
REQ-008 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ready is sampled high.
REQ-009 SHALL, in VEC, read VTOR_BASE + {exc_num, 2'b00}; on mem_ready it SHALL latch mem_rdata & ~32'h1 and go to ENTER.
REQ-010 SHALL, for exactly one cycle in ENTER, pulse ld_sp (w_SP = base), ld_pc (latched vector), ld_lr (w_LR = 32'hFFFF_FFF9), ld_ipsr (w_IPSR = exc_num) and done, then return to IDLE.
REQ-011 SHALL, on exit accept, latch base = r_SP and go to POP, reading base + 4k for k = 0..7.
REQ-012 SHALL, in POP, on each mem_ready in the same cycle: drive ld_rd with addr_Rd/w_Rd = mem_rdata for k = 0..4; drive ld_lr for k = 5; drive ld_pc with mem_rdata & ~1 for k = 6; drive ld_apsr = rdata[31:28] and ld_ipsr = rdata[5:0] for k = 7.
REQ-013 SHALL, for one cycle in RET, pulse ld_sp (w_SP = base + 32) and done, then return to IDLE.
REQ-014 SHALL hold busy high in every state except IDLE, and hold every ld_* low except where stated above.
REQ-015 SHALL take 11 cycles from entry accept to done with mem_ready tied high, and 9 cycles for exit.
REQ-016 SHALL wrap all address arithmetic modulo 2^32.

Reset
REQ-017 SHALL, on rst (including mid-sequence), go to IDLE with busy, done, mem_req, mem_we and all ld_* at 0 and all data/address outputs at 0; partial frame writes SHALL NOT be undone.

Configuration
REQ-018 SHALL, with EXC_PRIMASK_EN defined, ignore exc_req while r_PMask=1 unless exc_num=2 (NMI); without EXC_PRIMASK_EN, r_PMask SHALL be unused and every exc_req accepted.

Structure
REQ-019 SHALL place the state enum, FRAME_BYTES=32, FRAME_BEATS=8, EXC_RETURN_VAL=32'hFFFF_FFF9 and the beat-to-register map constants in shared package exc_pkg.
REQ-020 SHALL implement the beat-index to register-index/xPSR mux as one sub-module, exc_frame_mux.

Verification
REQ-021 SHALL cover: r_SP=0x2000_0100, R0=0xFEFE_FE00, exc_num=5, VTOR_BASE=0, ready tied high, word 0x14 = 0x0000_0201 -> writes 0x2000_00E0..FC, R0 at 0x2000_00E0, w_PC=0x0000_0200, w_SP=0x2000_00E0, w_LR=0xFFFF_FFF9, w_IPSR=5, done at cycle 11.
REQ-022 SHALL cover: exit with r_SP=0x2000_00E0 and frame contents from REQ-021 -> R0 restored to 0xFEFE_FE00, IPSR=0, w_SP=0x2000_0100, done at cycle 9.
REQ-023 SHALL cover: mem_ready low 3 cycles per beat -> addr/data held stable, entry latency = 8*4+4+... matches beat count, no duplicate beats.
REQ-024 SHALL cover: exc_req and exc_ret high together in IDLE -> entry taken; exc_req during PUSH -> ignored.
REQ-025 SHALL cover: rst asserted at PUSH beat 3 -> next cycle IDLE, busy=0, no ld_* pulse.
REQ-026 SHALL cover: EXC_PRIMASK_EN defined, r_PMask=1 -> exc_num=5 ignored, exc_num=2 accepted.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception stack sequencer.
// The frame layout is eight words: R0-R3, R12, LR, PC, xPSR.
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_VEC,
        ST_ENTER,
        ST_POP,
        ST_RET
    } state_t;

    localparam logic [31:0] FRAME_BYTES    = 32'd32;
    localparam int          FRAME_BEATS    = 8;
    localparam logic [31:0] EXC_RETURN_VAL = 32'hFFFF_FFF9;

    localparam logic [2:0]  BEAT_R12  = 3'd4;
    localparam logic [2:0]  BEAT_LR   = 3'd5;
    localparam logic [2:0]  BEAT_PC   = 3'd6;
    localparam logic [2:0]  BEAT_XPSR = 3'd7;
    localparam logic [2:0]  BEAT_LAST = 3'(FRAME_BEATS - 1);
    localparam logic [3:0]  REG_R12   = 4'd12;

    function automatic logic [3:0] beat_to_reg(input logic [2:0] beat);
        return (beat == BEAT_R12) ? REG_R12 : {1'b0, beat};
    endfunction

    function automatic logic [31:0] xpsr_word(input logic [3:0] apsr, input logic [5:0] ipsr);
        return {apsr, 22'b0, ipsr};
    endfunction

endpackage

// File: rtl/exc_stack_ctrl_if.sv
// Word-addressed memory beat port; a beat holds until mem_ready is sampled high.
// master = sequencer side, slave = memory side.
interface exc_stack_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/exc_frame_mux.sv
// Maps a frame beat index to its register-file index and push word.
// Purely combinational; no flow control.
module exc_frame_mux
    import exc_pkg::*;
(
    input  logic [2:0]  i_beat,
    input  logic [31:0] i_rn,
    input  logic [31:0] i_lr,
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_apsr,
    input  logic [5:0]  i_ipsr,
    output logic [3:0]  o_reg_idx,
    output logic [31:0] o_word
);
    always_comb begin
        o_reg_idx = beat_to_reg(i_beat);
        case (i_beat)
            BEAT_LR:   o_word = i_lr;
            BEAT_PC:   o_word = i_pc;
            BEAT_XPSR: o_word = xpsr_word(i_apsr, i_ipsr);
            default:   o_word = i_rn;
        endcase
    end
endmodule

// File: rtl/exc_stack_ctrl.sv
// Exception entry/exit stack sequencer; EXC_PRIMASK_EN adds PRIMASK gating of entries.
// Entry done 11 cycles after accept, exit 9, at zero wait; each bus beat stalls until mem_ready.
module exc_stack_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] VTOR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [5:0]  exc_num,
    input  logic        exc_ret,
    output logic        busy,
    output logic        done,
    exc_stack_ctrl_if.master mem,
    output logic [3:0]  addr_Rn,
    input  logic [31:0] Rn,
    input  logic [31:0] r_SP,
    input  logic [31:0] r_LR,
    input  logic [31:0] r_PC,
    input  logic [3:0]  r_APSR,
    input  logic [5:0]  r_IPSR,
    input  logic        r_PMask,
    output logic        ld_sp,
    output logic [31:0] w_SP,
    output logic        ld_lr,
    output logic [31:0] w_LR,
    output logic        ld_pc,
    output logic [31:0] w_PC,
    output logic        ld_rd,
    output logic [3:0]  addr_Rd,
    output logic [31:0] w_Rd,
    output logic        ld_apsr,
    output logic [3:0]  w_APSR,
    output logic        ld_ipsr,
    output logic [5:0]  w_IPSR
);
    state_t      r_state, w_next;
    logic [2:0]  r_beat;
    logic [31:0] r_base;
    logic [5:0]  r_num;
    logic [31:0] r_vec;
    logic        r_vec_ph;
    logic        w_take_entry;
    logic [3:0]  w_reg_idx;
    logic [31:0] w_word;
    logic [31:0] w_beat_addr;
    logic [31:0] w_vec_addr;

`ifdef EXC_PRIMASK_EN
    assign w_take_entry = exc_req && (!r_PMask || exc_num == 6'd2);
`else
    logic w_unused_pmask;
    assign w_unused_pmask = r_PMask;
    assign w_take_entry   = exc_req;
`endif

    assign w_beat_addr = r_base + {27'd0, r_beat, 2'b00};
    assign w_vec_addr  = VTOR_BASE + {24'd0, r_num, 2'b00};

    exc_frame_mux u_frame_mux (
        .i_beat    (r_beat),
        .i_rn      (Rn),
        .i_lr      (r_LR),
        .i_pc      (r_PC),
        .i_apsr    (r_APSR),
        .i_ipsr    (r_IPSR),
        .o_reg_idx (w_reg_idx),
        .o_word    (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_beat   <= 3'd0;
            r_base   <= 32'd0;
            r_num    <= 6'd0;
            r_vec    <= 32'd0;
            r_vec_ph <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    r_beat   <= 3'd0;
                    r_vec_ph <= 1'b0;
                    if (w_take_entry) begin
                        r_base <= r_SP - FRAME_BYTES;
                        r_num  <= exc_num;
                    end else if (exc_ret) begin
                        r_base <= r_SP;
                    end
                end
                ST_PUSH, ST_POP: if (mem.mem_ready) r_beat <= r_beat + 3'd1;
                // One idle bus cycle separates the write burst from the vector fetch.
                ST_VEC: begin
                    if (!r_vec_ph) begin
                        r_vec_ph <= 1'b1;
                    end else if (mem.mem_ready) begin
                        r_vec    <= mem.mem_rdata & ~32'h1;
                        r_vec_ph <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_take_entry) w_next = ST_PUSH;
                      else if (exc_ret) w_next = ST_POP;
            ST_PUSH:  if (mem.mem_ready && r_beat == BEAT_LAST) w_next = ST_VEC;
            ST_VEC:   if (r_vec_ph && mem.mem_ready) w_next = ST_ENTER;
            ST_ENTER: w_next = ST_IDLE;
            ST_POP:   if (mem.mem_ready && r_beat == BEAT_LAST) w_next = ST_RET;
            ST_RET:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (r_state != ST_IDLE);
        done          = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 32'd0;
        addr_Rn       = 4'd0;
        ld_sp = 1'b0; w_SP = 32'd0;
        ld_lr = 1'b0; w_LR = 32'd0;
        ld_pc = 1'b0; w_PC = 32'd0;
        ld_rd = 1'b0; addr_Rd = 4'd0; w_Rd = 32'd0;
        ld_apsr = 1'b0; w_APSR = 4'd0;
        ld_ipsr = 1'b0; w_IPSR = 6'd0;
        case (r_state)
            ST_PUSH: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = w_beat_addr;
                mem.mem_wdata = w_word;
                if (r_beat < BEAT_LR) addr_Rn = w_reg_idx;
            end
            ST_VEC: begin
                mem.mem_req  = r_vec_ph;
                mem.mem_addr = r_vec_ph ? w_vec_addr : 32'd0;
            end
            ST_ENTER: begin
                ld_sp = 1'b1; w_SP = r_base;
                ld_pc = 1'b1; w_PC = r_vec;
                ld_lr = 1'b1; w_LR = EXC_RETURN_VAL;
                ld_ipsr = 1'b1; w_IPSR = r_num;
                done = 1'b1;
            end
            ST_POP: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = w_beat_addr;
                if (mem.mem_ready) begin
                    if (r_beat < BEAT_LR) begin
                        ld_rd = 1'b1; addr_Rd = w_reg_idx; w_Rd = mem.mem_rdata;
                    end else if (r_beat == BEAT_LR) begin
                        ld_lr = 1'b1; w_LR = mem.mem_rdata;
                    end else if (r_beat == BEAT_PC) begin
                        ld_pc = 1'b1; w_PC = mem.mem_rdata & ~32'h1;
                    end else begin
                        ld_apsr = 1'b1; w_APSR = mem.mem_rdata[31:28];
                        ld_ipsr = 1'b1; w_IPSR = mem.mem_rdata[5:0];
                    end
                end
            end
            ST_RET: begin
                ld_sp = 1'b1; w_SP = r_base + FRAME_BYTES;
                done  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_exc_stack_ctrl.sv
// Directed scoreboard bench for exc_stack_ctrl: bus beats and load strobes are
// predicted when a request is driven and checked as the DUT produces them.
module tb_exc_stack_ctrl;
    localparam logic [31:0] VTOR    = 32'h0000_0000;
    localparam logic [31:0] EXC_RET = 32'hFFFF_FFF9;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req, exc_ret;
    logic [5:0]  exc_num;
    logic        busy, done;
    logic [3:0]  addr_Rn;
    logic [31:0] Rn;
    logic [31:0] r_SP, r_LR, r_PC;
    logic [3:0]  r_APSR;
    logic [5:0]  r_IPSR;
    logic        r_PMask;
    logic        ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr;
    logic [31:0] w_SP, w_LR, w_PC, w_Rd;
    logic [3:0]  addr_Rd, w_APSR;
    logic [5:0]  w_IPSR;

    exc_stack_ctrl_if mem_bus();

    exc_stack_ctrl #(.VTOR_BASE(VTOR)) dut (
        .clk(clk), .rst(rst), .exc_req(exc_req), .exc_num(exc_num), .exc_ret(exc_ret),
        .busy(busy), .done(done), .mem(mem_bus), .addr_Rn(addr_Rn), .Rn(Rn),
        .r_SP(r_SP), .r_LR(r_LR), .r_PC(r_PC), .r_APSR(r_APSR), .r_IPSR(r_IPSR),
        .r_PMask(r_PMask), .ld_sp(ld_sp), .w_SP(w_SP), .ld_lr(ld_lr), .w_LR(w_LR),
        .ld_pc(ld_pc), .w_PC(w_PC), .ld_rd(ld_rd), .addr_Rd(addr_Rd), .w_Rd(w_Rd),
        .ld_apsr(ld_apsr), .w_APSR(w_APSR), .ld_ipsr(ld_ipsr), .w_IPSR(w_IPSR)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } beat_t;

    typedef struct packed {
        logic        ld_sp;   logic [31:0] sp;
        logic        ld_lr;   logic [31:0] lr;
        logic        ld_pc;   logic [31:0] pc;
        logic        ld_rd;   logic [3:0]  rd_idx; logic [31:0] rd;
        logic        ld_apsr; logic [3:0]  apsr;
        logic        ld_ipsr; logic [5:0]  ipsr;
        logic        done;
    } ld_t;

    logic [31:0] rf [16];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] frame [8];
    beat_t       bus_q [$];
    ld_t         ld_q  [$];
    beat_t       bus_obs, bus_exp;
    ld_t         ld_obs, ld_exp;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          stall_n = 0;
    int          wait_cnt = 0;
    logic [219:0] all_out;

    assign Rn = rf[addr_Rn];
    assign all_out = {busy, done, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr,
                      mem_bus.mem_wdata, addr_Rn, ld_sp, w_SP, ld_lr, w_LR, ld_pc, w_PC,
                      ld_rd, addr_Rd, w_Rd, ld_apsr, w_APSR, ld_ipsr, w_IPSR};

    // Memory responder plus bus/load scoreboard checkers, sampled on the falling edge.
    initial begin
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_bus.mem_ready = (wait_cnt >= stall_n);
            mem_bus.mem_rdata = mem_model.exists(mem_bus.mem_addr) ? mem_model[mem_bus.mem_addr] : 32'h0;
            @(negedge clk);
            if (mem_bus.mem_req === 1'b1) begin
                bus_obs = '{mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_we ? mem_bus.mem_wdata : 32'h0};
                n_tests++;
                assert (bus_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL bus_extra obs=%h exp=none", bus_obs);
                end
                if (bus_q.size() > 0) begin
                    n_tests++;
                    assert (bus_obs === bus_q[0]) else begin
                        n_fail++;
                        $error("FAIL bus_beat obs=%h exp=%h", bus_obs, bus_q[0]);
                    end
                    if (mem_bus.mem_ready) bus_exp = bus_q.pop_front();
                end
                if (mem_bus.mem_ready) begin
                    if (mem_bus.mem_we) mem_model[mem_bus.mem_addr] = mem_bus.mem_wdata;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            ld_obs = '{ld_sp, w_SP, ld_lr, w_LR, ld_pc, w_PC, ld_rd, addr_Rd, w_Rd,
                       ld_apsr, w_APSR, ld_ipsr, w_IPSR, done};
            if (ld_obs != '0) begin
                n_tests++;
                assert (ld_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL ld_extra obs=%h exp=none", ld_obs);
                end
                if (ld_q.size() > 0) begin
                    ld_exp = ld_q.pop_front();
                    n_tests++;
                    assert (ld_obs === ld_exp) else begin
                        n_fail++;
                        $error("FAIL ld_event obs=%h exp=%h", ld_obs, ld_exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_entry(input logic [5:0] num);
        logic [31:0] base, vaddr, vec;
        ld_t e;
        base = r_SP - 32'd32;
        for (int k = 0; k < 4; k++) frame[k] = rf[k];
        frame[4] = rf[12];
        frame[5] = r_LR;
        frame[6] = r_PC;
        frame[7] = {r_APSR, 22'h0, r_IPSR};
        for (int k = 0; k < 8; k++) bus_q.push_back('{1'b1, base + 32'(4 * k), frame[k]});
        vaddr = VTOR + {24'h0, num, 2'b00};
        bus_q.push_back('{1'b0, vaddr, 32'h0});
        vec = mem_model[vaddr];
        e = '0;
        e.ld_sp = 1'b1; e.sp = base;
        e.ld_lr = 1'b1; e.lr = EXC_RET;
        e.ld_pc = 1'b1; e.pc = {vec[31:1], 1'b0};
        e.ld_ipsr = 1'b1; e.ipsr = num;
        e.done = 1'b1;
        ld_q.push_back(e);
    endtask

    task automatic push_exit(input logic [31:0] sp);
        ld_t e;
        logic [31:0] w;
        for (int k = 0; k < 8; k++) begin
            bus_q.push_back('{1'b0, sp + 32'(4 * k), 32'h0});
            w = frame[k];
            e = '0;
            if (k < 5) begin
                e.ld_rd = 1'b1; e.rd_idx = (k == 4) ? 4'd12 : 4'(k); e.rd = w;
            end else if (k == 5) begin
                e.ld_lr = 1'b1; e.lr = w;
            end else if (k == 6) begin
                e.ld_pc = 1'b1; e.pc = {w[31:1], 1'b0};
            end else begin
                e.ld_apsr = 1'b1; e.apsr = w[31:28];
                e.ld_ipsr = 1'b1; e.ipsr = w[5:0];
            end
            ld_q.push_back(e);
        end
        e = '0;
        e.ld_sp = 1'b1; e.sp = sp + 32'd32; e.done = 1'b1;
        ld_q.push_back(e);
    endtask

    // Cycle 1 is the first cycle after the accepting edge; poke re-raises both requests mid-sequence.
    task automatic start_and_wait(input logic req, input logic ret, input logic [5:0] num,
                                  input int exp_cyc, input int poke, input string tag);
        int   cyc;
        logic got;
        exc_req = req; exc_ret = ret; exc_num = num;
        @(posedge clk);
        #1;
        exc_req = 1'b0; exc_ret = 1'b0;
        cyc = 1; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                exc_req = (cyc == poke);
                exc_ret = (cyc == poke);
                if (cyc == poke) exc_num = 6'd9;
                @(posedge clk);
                cyc++;
            end
        end
        exc_req = 1'b0; exc_ret = 1'b0;
        n_tests++;
        assert (got && cyc == exp_cyc) else begin
            n_fail++;
            $error("FAIL %s done_cycle obs=%0d exp=%0d seen=%0b", tag, cyc, exp_cyc, got);
        end
    endtask

    initial begin
        rst = 1'b1; exc_req = 1'b0; exc_ret = 1'b0; exc_num = 6'd0;
        r_SP = 32'h0; r_LR = 32'h0800_0123; r_PC = 32'h0000_1000;
        r_APSR = 4'h6; r_IPSR = 6'd0; r_PMask = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 32'hFEFE_FE00 + 32'(i);
        mem_model[VTOR + 32'h14] = 32'h0000_0201;
        mem_model[VTOR + 32'h1C] = 32'h0000_0301;
        mem_model[VTOR + 32'h0C] = 32'h0000_0401;
        mem_model[VTOR + 32'h08] = 32'h0000_0501;

        repeat (3) @(negedge clk);
        n_tests++;
        assert (all_out === '0) else begin
            n_fail++;
            $error("FAIL reset_outputs obs=%h exp=0", all_out);
        end
        rst = 1'b0;
        idle(1);

        // Basic entry, zero wait states
        r_SP = 32'h2000_0100;
        push_entry(6'd5);
        start_and_wait(1'b1, 1'b0, 6'd5, 11, -1, "entry_latency");
        chk("entry_r0_word", 64'(mem_model[32'h2000_00E0]), 64'hFEFE_FE00);
        idle(2);
        chk("entry_drain", 64'(bus_q.size() + ld_q.size()), 64'd0);

        // Matching exit from the handler
        r_SP = 32'h2000_00E0; r_IPSR = 6'd5;
        push_exit(32'h2000_00E0);
        start_and_wait(1'b0, 1'b1, 6'd0, 9, -1, "exit_latency");
        idle(2);
        chk("exit_drain", 64'(bus_q.size() + ld_q.size()), 64'd0);

        // Three wait states on every beat
        stall_n = 3; r_IPSR = 6'd0; r_SP = 32'h2000_0400;
        push_entry(6'd7);
        start_and_wait(1'b1, 1'b0, 6'd7, 38, -1, "stall_entry_latency");
        idle(2);
        chk("stall_entry_drain", 64'(bus_q.size() + ld_q.size()), 64'd0);
        r_SP = 32'h2000_03E0;
        push_exit(32'h2000_03E0);
        start_and_wait(1'b0, 1'b1, 6'd0, 33, -1, "stall_exit_latency");
        idle(2);
        chk("stall_exit_drain", 64'(bus_q.size() + ld_q.size()), 64'd0);
        stall_n = 0;

        // Both requests together, then requests raised during PUSH
        r_SP = 32'h2000_0600;
        push_entry(6'd3);
        start_and_wait(1'b1, 1'b1, 6'd3, 11, 3, "both_req_entry");
        idle(3);
        chk("no_reentry_busy", 64'(busy), 64'd0);
        chk("both_req_drain", 64'(bus_q.size() + ld_q.size()), 64'd0);

        // Reset during PUSH beat 3
        r_SP = 32'h2000_0800;
        push_entry(6'd5);
        exc_req = 1'b1; exc_num = 6'd5;
        @(posedge clk);
        #1;
        exc_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        assert (all_out === '0) else begin
            n_fail++;
            $error("FAIL rst_midpush_outputs obs=%h exp=0", all_out);
        end
        rst = 1'b0;
        bus_q.delete();
        ld_q.delete();
        idle(3);
        chk("rst_busy_after", 64'(busy), 64'd0);
        chk("rst_partial_kept", 64'(mem_model[32'h2000_07EC]), 64'(rf[3]));
        chk("rst_no_beat4", 64'(mem_model.exists(32'h2000_07F0)), 64'd0);

`ifdef EXC_PRIMASK_EN
        r_PMask = 1'b1; r_SP = 32'h2000_0A00;
        exc_req = 1'b1; exc_num = 6'd5;
        repeat (3) @(negedge clk);
        chk("pmask_blocked_busy", 64'(busy), 64'd0);
        exc_req = 1'b0;
        idle(1);
        push_entry(6'd2);
        start_and_wait(1'b1, 1'b0, 6'd2, 11, -1, "pmask_nmi_entry");
`else
        r_PMask = 1'b1; r_SP = 32'h2000_0A00;
        push_entry(6'd5);
        start_and_wait(1'b1, 1'b0, 6'd5, 11, -1, "pmask_ignored_entry");
`endif
        idle(2);
        chk("pmask_drain", 64'(bus_q.size() + ld_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
